// File: rtl/sysbus_pkg.sv
// sysbus_pkg: shared read tag, reader FSM states and line offset helper
package sysbus_pkg;
    localparam int READ_TAG = 'h0A5;
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
    function automatic int line_off_w(input int beats, input int data_width);
        return $clog2(beats * data_width / 8);
    endfunction
    localparam int LINE_OFF_W = line_off_w(8, 64);
endpackage

// File: rtl/line_assembler.sv
// line_assembler: collects bus beats into one line, beat 0 in the low bits
module line_assembler #(
    parameter int DATA_WIDTH = 64,
    parameter int BEATS      = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        we,
    input  logic [DATA_WIDTH-1:0]       data,
    output logic [BEATS*DATA_WIDTH-1:0] line,
    output logic                        last
);
    localparam int CW = $clog2(BEATS);
    logic [CW-1:0] count;
    // the counter wraps to 0 on the last beat since BEATS is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            line  <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (we) begin
            line[count*DATA_WIDTH +: DATA_WIDTH] <= data;
            count <= count + 1'b1;
        end
    end
    assign last = count == CW'(BEATS - 1);
endmodule

// File: rtl/sysbus_line_reader.sv
// sysbus_line_reader: issues one tagged line read on the system bus and
// assembles the returned beats into a full line for the core
module sysbus_line_reader
    import sysbus_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 13,
    parameter int BEATS      = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rd_valid,
    input  logic [63:0]                 rd_addr,
    output logic                        rd_ready,
    output logic                        line_valid,
    output logic [BEATS*DATA_WIDTH-1:0] line_data,
    output logic [63:0]                 line_addr,
    input  logic                        line_ready,
    output logic [DATA_WIDTH-1:0]       req,
    output logic [TAG_WIDTH-1:0]        reqtag,
    output logic                        reqcyc,
    input  logic                        reqack,
    input  logic [DATA_WIDTH-1:0]       resp,
    input  logic [TAG_WIDTH-1:0]        resptag,
    input  logic                        respcyc,
    output logic                        respack
);
    localparam int OFF = line_off_w(BEATS, DATA_WIDTH);
    state_t      state, nxt;
    logic [63:0] addr_q;
    logic        accept, beat_ok, last;
    assign accept  = state == IDLE && rd_valid;
    assign beat_ok = state == RESP && respcyc && resptag == TAG_WIDTH'(READ_TAG);
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = rd_valid ? REQ : IDLE;
            REQ:     nxt = reqack ? RESP : REQ;
            RESP:    nxt = beat_ok && last ? DONE : RESP;
            DONE:    nxt = line_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            addr_q <= '0;
        end else begin
            state <= nxt;
            if (accept) addr_q <= {rd_addr[63:OFF], OFF'(0)};
        end
    end
    line_assembler #(.DATA_WIDTH(DATA_WIDTH), .BEATS(BEATS)) u_asm (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .we    (beat_ok),
        .data  (resp),
        .line  (line_data),
        .last  (last)
    );
    assign rd_ready   = state == IDLE;
    assign reqcyc     = state == REQ;
    assign req        = DATA_WIDTH'(addr_q);
    assign reqtag     = TAG_WIDTH'(READ_TAG);
    assign respack    = beat_ok;
    assign line_valid = state == DONE;
    assign line_addr  = addr_q;
endmodule

// File: tb/tb_sysbus_line_reader.sv
// tb_sysbus_line_reader: scenario tasks with a scoreboard of expected lines
module tb_sysbus_line_reader;
    localparam logic [12:0] TAG = 13'(sysbus_pkg::READ_TAG);
    logic clk = 0, reset = 1;
    logic rd_valid = 0, line_ready = 0, reqack = 0, respcyc = 0;
    logic [63:0] rd_addr = '0, resp = '0;
    logic [12:0] resptag = '0;
    logic rd_ready, line_valid, reqcyc, respack;
    logic [511:0] line_data;
    logic [63:0] line_addr, req;
    logic [12:0] reqtag;
    int errors = 0, checks = 0;
    typedef struct {
        logic [63:0]  a;
        logic [511:0] d;
    } exp_t;
    exp_t sb[$];

    sysbus_line_reader dut (
        .clk(clk), .reset(reset), .rd_valid(rd_valid), .rd_addr(rd_addr),
        .rd_ready(rd_ready), .line_valid(line_valid), .line_data(line_data),
        .line_addr(line_addr), .line_ready(line_ready), .req(req),
        .reqtag(reqtag), .reqcyc(reqcyc), .reqack(reqack), .resp(resp),
        .resptag(resptag), .respcyc(respcyc), .respack(respack)
    );

    always #5 clk = ~clk;

    // scoreboard: every line handed over must match the oldest expected line
    always @(negedge clk) begin
        if (!reset && line_valid && line_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL line_unexpected addr=%h", line_addr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (line_addr !== e.a || line_data !== e.d) begin
                    errors++;
                    $display("FAIL line_content addr=%h want %h data=%h want %h",
                             line_addr, e.a, line_data, e.d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] mk(input logic [63:0] base);
        logic [511:0] l;
        for (int i = 0; i < 8; i++) l[i*64 +: 64] = base + 64'(i);
        return l;
    endfunction

    task automatic request(input logic [63:0] a);
        rd_valid = 1;
        rd_addr  = a;
        tick();
        rd_valid = 0;
    endtask

    task automatic beat(input logic [63:0] d, input logic [12:0] t);
        respcyc = 1;
        resp    = d;
        resptag = t;
        tick();
        respcyc = 0;
    endtask

    task automatic wait_drain(input string name);
        line_ready = 1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        line_ready = 0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1;
        tick();
        checks++;
        if ({rd_ready, reqcyc, respack, line_valid} !== 4'b1000 || line_data !== '0 || line_addr !== '0) begin
            errors++;
            $display("FAIL reset_in rdy/cyc/ack/valid=%b want 1000 data0=%b addr=%h",
                     {rd_ready, reqcyc, respack, line_valid}, line_data == '0, line_addr);
        end
        reset = 0;
        tick();
        checks++;
        if ({rd_ready, reqcyc, respack, line_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_after rdy/cyc/ack/valid=%b want 1000", {rd_ready, reqcyc, respack, line_valid});
        end
    endtask

    task automatic test_basic();
        int cyc = 0;
        sb.push_back('{64'h1234_5640, mk(0)});
        request(64'h1234_5678);
        cyc++;
        checks++;
        if (reqcyc !== 1 || req !== 64'h1234_5640 || reqtag !== TAG || rd_ready !== 0) begin
            errors++;
            $display("FAIL basic_req cyc=%b req=%h tag=%h rdy=%b want 1 1234_5640 %h 0",
                     reqcyc, req, reqtag, rd_ready, TAG);
        end
        reqack = 1;
        tick();
        cyc++;
        reqack = 0;
        for (int i = 0; i < 8; i++) begin
            respcyc = 1;
            resp    = 64'(i);
            resptag = TAG;
            #1;
            checks++;
            if (respack !== 1 || line_valid !== 0) begin
                errors++;
                $display("FAIL basic_beat%0d ack=%b valid=%b want 1 0", i, respack, line_valid);
            end
            tick();
            cyc++;
            respcyc = 0;
        end
        checks++;
        if (line_valid !== 1 || cyc != 10 || line_addr !== 64'h1234_5640) begin
            errors++;
            $display("FAIL basic_latency valid=%b cycles=%0d addr=%h want 1 10 1234_5640",
                     line_valid, cyc, line_addr);
        end
        wait_drain("basic");
        checks++;
        if (rd_ready !== 1 || line_valid !== 0) begin
            errors++;
            $display("FAIL basic_idle rdy=%b valid=%b want 1 0", rd_ready, line_valid);
        end
    endtask

    task automatic test_delayed_ack();
        sb.push_back('{64'hABCD_0000_0000_1000, mk(64'h100)});
        request(64'hABCD_0000_0000_103F);
        respcyc = 1;
        resptag = TAG;
        resp    = 64'hDEAD;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (reqcyc !== 1 || req !== 64'hABCD_0000_0000_1000 || reqtag !== TAG || respack !== 0) begin
                errors++;
                $display("FAIL delay_hold%0d cyc=%b req=%h tag=%h ack=%b want 1 abcd000000001000 %h 0",
                         k, reqcyc, req, reqtag, respack, TAG);
            end
            tick();
        end
        respcyc = 0;
        reqack  = 1;
        tick();
        reqack = 0;
        for (int i = 0; i < 8; i++) beat(64'h100 + 64'(i), TAG);
        wait_drain("delay");
    endtask

    task automatic test_bad_tag();
        sb.push_back('{64'h0000_0000_0000_2000, mk(64'h200)});
        request(64'h2010);
        reqack = 1;
        tick();
        reqack = 0;
        for (int i = 0; i < 4; i++) beat(64'h200 + 64'(i), TAG);
        respcyc = 1;
        resp    = 64'hBAD;
        resptag = TAG ^ 13'h1;
        #1;
        checks++;
        if (respack !== 0) begin
            errors++;
            $display("FAIL badtag_ack ack=%b want 0", respack);
        end
        tick();
        respcyc = 0;
        for (int i = 4; i < 8; i++) beat(64'h200 + 64'(i), TAG);
        wait_drain("badtag");
    endtask

    task automatic test_gaps();
        logic [511:0] e;
        e = mk(64'h300);
        sb.push_back('{64'h0000_0000_0000_3040, e});
        request(64'h307F);
        reqack = 1;
        tick();
        reqack = 0;
        for (int i = 0; i < 8; i++) begin
            beat(64'h300 + 64'(i), TAG);
            if (i < 7) begin
                tick();
                tick();
            end
        end
        rd_valid = 1;
        rd_addr  = 64'h9999_0000;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (line_valid !== 1 || line_data !== e || rd_ready !== 0 || reqcyc !== 0) begin
                errors++;
                $display("FAIL gaps_hold%0d valid=%b data_ok=%b rdy=%b cyc=%b want 1 1 0 0",
                         k, line_valid, line_data == e, rd_ready, reqcyc);
            end
            tick();
        end
        rd_valid = 0;
        wait_drain("gaps");
        checks++;
        if (rd_ready !== 1 || reqcyc !== 0) begin
            errors++;
            $display("FAIL gaps_noqueue rdy=%b cyc=%b want 1 0", rd_ready, reqcyc);
        end
    endtask

    task automatic test_reset_mid();
        request(64'h4000);
        reqack = 1;
        tick();
        reqack = 0;
        for (int i = 0; i < 5; i++) beat(64'h4000 + 64'(i), TAG);
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if ({rd_ready, reqcyc, line_valid, respack} !== 4'b1000) begin
            errors++;
            $display("FAIL rstmid_idle rdy/cyc/valid/ack=%b want 1000", {rd_ready, reqcyc, line_valid, respack});
        end
        sb.push_back('{64'h0000_0000_0000_5000, mk(64'h500)});
        request(64'h5008);
        reqack = 1;
        tick();
        reqack = 0;
        for (int i = 0; i < 8; i++) beat(64'h500 + 64'(i), TAG);
        wait_drain("rstmid");
    endtask

    task automatic test_idle_resp();
        respcyc = 1;
        resptag = TAG;
        resp    = 64'h77;
        #1;
        checks++;
        if (respack !== 0) begin
            errors++;
            $display("FAIL idleresp_ack ack=%b want 0", respack);
        end
        tick();
        respcyc = 0;
        checks++;
        if (rd_ready !== 1 || reqcyc !== 0 || line_valid !== 0) begin
            errors++;
            $display("FAIL idleresp_state rdy=%b cyc=%b valid=%b want 1 0 0", rd_ready, reqcyc, line_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delayed_ack();
        test_bad_tag();
        test_gaps();
        test_reset_mid();
        test_idle_resp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sysbus_line_reader.md
SYSBUS_LINE_READER -- requirements
Module: sysbus_line_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, bus data width in bits.
REQ-002 SHALL have parameter TAG_WIDTH, default 13, bus tag width in bits.
REQ-003 SHALL have parameter BEATS, default 8, data beats per line; power of two, 2 to 16.
REQ-004 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 rd_valid  in  1  core line-read request valid.
REQ-007 rd_addr  in  64  byte address of requested line.
REQ-008 rd_ready  out  1  block can accept a request.
REQ-009 line_valid  out  1  assembled line available.
REQ-010 line_data  out  BEATS*DATA_WIDTH  assembled line; beat 0 in least-significant bits.
REQ-011 line_addr  out  64  line-aligned address of line_data.
REQ-012 line_ready  in  1  consumer accepts line.
REQ-013 req  out  DATA_WIDTH  bus request payload (line address).
REQ-014 reqtag  out  TAG_WIDTH  bus request tag.
REQ-015 reqcyc  out  1  bus request valid.
REQ-016 reqack  in  1  bus accepted request.
REQ-017 resp  in  DATA_WIDTH  bus response beat.
REQ-018 resptag  in  TAG_WIDTH  tag of response beat.
REQ-019 respcyc  in  1  response beat valid.
REQ-020 respack  out  1  response beat consumed.

Function
REQ-021 SHALL implement FSM states IDLE, REQ, RESP, DONE.
REQ-022 IDLE: rd_ready=1; on rd_valid, SHALL latch rd_addr with low log2(BEATS*DATA_WIDTH/8) bits cleared, clear beat counter, go to REQ next cycle.
REQ-023 REQ: reqcyc=1, req=latched address, reqtag=READ_TAG; all held stable until reqack; on reqack go to RESP next cycle.
REQ-024 reqack while in REQ and reqcyc high SHALL be honoured in the same cycle reqcyc first asserts (zero-wait acceptance).
REQ-025 RESP: respack SHALL be combinational = respcyc AND (resptag == READ_TAG); each such beat written into slot beat_count, beat_count incremented.
REQ-026 Beats with resptag != READ_TAG SHALL be ignored: respack=0, no data or counter change.
REQ-027 When beat BEATS-1 is accepted, SHALL go to DONE next cycle; counter wraps to 0.
REQ-028 DONE: line_valid=1, line_data/line_addr stable; on line_ready go to IDLE next cycle.
REQ-029 rd_ready SHALL be 1 only in IDLE; rd_valid outside IDLE SHALL be ignored (no queuing).
REQ-030 respcyc outside RESP SHALL be ignored with respack=0; reqack outside REQ SHALL be ignored.
REQ-031 Minimum request-to-line latency SHALL be 2+BEATS cycles (accept, REQ with immediate reqack, BEATS back-to-back beats, line_valid the cycle after the last beat).
REQ-032 Only one outstanding request SHALL exist at any time.

Reset
REQ-033 On reset SHALL enter IDLE, clear beat counter, line_data, line_addr and latched address to 0.
REQ-034 During and after reset: reqcyc=0, respack=0, line_valid=0, rd_ready=1 (IDLE).
REQ-035 Reset in REQ, RESP or DONE SHALL abandon the transaction; partially assembled data is not presented.

Structure
REQ-036 Shared package sysbus_pkg SHALL hold READ_TAG, the FSM state enum type, and the line byte-offset width constant.
REQ-037 Beat storage and counter SHALL live in sub-module line_assembler (write-enable, beat data, clear; presents full line); FSM in this module.

Verification
REQ-038 rd_addr=0x1234_5678, reqack same cycle as reqcyc, 8 back-to-back matching beats 0..7 -> req=0x1234_5640, line_valid after 10 cycles, line_addr=0x1234_5640, line_data beat i = i.
REQ-039 reqack delayed 5 cycles -> req/reqtag/reqcyc stable all 5 cycles, no respack before reqack.
REQ-040 Beat with resptag=READ_TAG^1 interleaved after beat 3 -> respack=0 that cycle, line still beats 0..7 in order.
REQ-041 Gaps of 2 idle cycles between beats and line_ready held low 4 cycles in DONE -> line_valid and data stable, rd_ready=0 until accept.
REQ-042 reset asserted after beat 4 in RESP -> next cycle IDLE, reqcyc=0, line_valid=0; new request completes with fresh data only.
REQ-043 respcyc pulsed in IDLE -> respack=0, no state change.
